// File: rtl/mandel_pkg.sv
// -----------------------------------------------------------------------------
// mandel_pkg
// Shared types and constants for the Mandelbrot coordinate datapath.
//   COORD_WL / COORD_FRAC : default signed fixed-point format (Q4.28)
//   coord_t               : signed coordinate word
//   FIXED_ONE             : 1.0 in the default format
//   state_t               : pixel_coord_stream frame sequencer states
// -----------------------------------------------------------------------------
package mandel_pkg;

  localparam int COORD_WL   = 32;
  localparam int COORD_FRAC = 28;

  typedef logic signed [COORD_WL-1:0] coord_t;

  localparam coord_t FIXED_ONE = coord_t'(1) <<< COORD_FRAC;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SCAN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/lane_offset_gen.sv
// -----------------------------------------------------------------------------
// lane_offset_gen
// Registered table of k*step for k = 0..NUM_LANES-1, built with shift-and-add
// so no multiplier is needed. The table is captured when load is high and
// holds until the next load.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   load       : capture k*step for all lanes
//   step       : signed per-pixel increment
//   offsets    : lane k offset at bits [k*WORD_LENGTH +: WORD_LENGTH]
// -----------------------------------------------------------------------------
module lane_offset_gen #(
  parameter int WORD_LENGTH = 32,
  parameter int NUM_LANES   = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               load,
  input  logic signed [WORD_LENGTH-1:0]      step,
  output logic [NUM_LANES*WORD_LENGTH-1:0]   offsets
);

  // k is at most 15, so five shifted partial terms cover every lane index.
  // Two's-complement wrap makes the unsigned sum equal the signed product.
  function automatic logic [WORD_LENGTH-1:0] scale(input logic [WORD_LENGTH-1:0] s,
                                                   input int k);
    logic [WORD_LENGTH-1:0] acc;
    acc = '0;
    for (int b = 0; b < 5; b++) begin
      if (((k >> b) & 1) != 0) acc = acc + (s << b);
    end
    return acc;
  endfunction

  // NOTE: the table is a handful of flops, not a RAM, so it is reset like any
  // other state; this keeps out_real at zero straight out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      offsets <= '0;
    end else if (load) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        offsets[k*WORD_LENGTH +: WORD_LENGTH] <= scale(step, k);
      end
    end
  end

endmodule

// File: rtl/pixel_coord_stream.sv
// -----------------------------------------------------------------------------
// pixel_coord_stream
// Raster-scanning pixel-to-complex mapper. A start pulse latches the view
// (centre, per-pixel step, screen size); the block then streams NUM_LANES
// consecutive pixels per beat as signed fixed-point (real, imag) over a
// valid/ready handshake, using incremental adds only.
//
// Build option: define PIXEL_CENTER_EN to sample pixel centres (half-step
// offset on both axes) instead of pixel top-left corners.
//
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   start                : begin a frame (honoured only when idle)
//   screen_width/height  : frame size in pixels (0 treated as 1)
//   real/imag_center     : signed view centre
//   step                 : signed per-pixel increment
//   busy                 : accepted start .. frame_done
//   out_valid/out_ready  : beat handshake
//   out_real             : lane i real at [i*WORD_LENGTH +: WORD_LENGTH]
//   out_imag             : row imaginary value, shared by all lanes
//   out_x / out_y        : x of lane 0, row index
//   out_lane_mask        : lane i holds a pixel inside the row
//   out_last             : final beat of the frame
//   frame_done           : one-cycle pulse after the final handshake
// -----------------------------------------------------------------------------
module pixel_coord_stream
  import mandel_pkg::*;
#(
  parameter int WORD_LENGTH = COORD_WL,
  parameter int FRAC        = COORD_FRAC,
  parameter int NUM_LANES   = 4,
  parameter int COORD_W     = 11
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [COORD_W-1:0]                screen_width,
  input  logic [COORD_W-1:0]                screen_height,
  input  logic signed [WORD_LENGTH-1:0]     real_center,
  input  logic signed [WORD_LENGTH-1:0]     imag_center,
  input  logic signed [WORD_LENGTH-1:0]     step,
  output logic                              busy,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [NUM_LANES*WORD_LENGTH-1:0]  out_real,
  output logic signed [WORD_LENGTH-1:0]     out_imag,
  output logic [COORD_W-1:0]                out_x,
  output logic [COORD_W-1:0]                out_y,
  output logic [NUM_LANES-1:0]              out_lane_mask,
  output logic                              out_last,
  output logic                              frame_done
);

  if (FRAC >= WORD_LENGTH || NUM_LANES < 1 || NUM_LANES > 16 ||
      (NUM_LANES & (NUM_LANES - 1)) != 0) begin : g_param_check
    $error("pixel_coord_stream: illegal parameter set");
  end

  localparam int PW         = COORD_W + WORD_LENGTH;
  localparam int LANE_SHIFT = $clog2(NUM_LANES);

  state_t state;

  // Configuration captured on the accepted start.
  logic [COORD_W-1:0]            cfg_w;
  logic [COORD_W-1:0]            cfg_h;
  logic signed [WORD_LENGTH-1:0] cfg_rc;
  logic signed [WORD_LENGTH-1:0] cfg_ic;
  logic signed [WORD_LENGTH-1:0] cfg_step;

  // Scan state.
  logic signed [WORD_LENGTH-1:0] real_min;
  logic signed [WORD_LENGTH-1:0] row_real;
  logic [NUM_LANES*WORD_LENGTH-1:0] lane_off;

  // Centre-to-edge offsets: full-width products, then wrapped to WORD_LENGTH.
  logic signed [PW-1:0]          step_ext;
  logic signed [PW-1:0]          half_w_ext;
  logic signed [PW-1:0]          half_h_ext;
  logic signed [WORD_LENGTH-1:0] real_min_calc;
  logic signed [WORD_LENGTH-1:0] imag_max_calc;
  logic signed [WORD_LENGTH-1:0] row_step;

  assign step_ext   = PW'(cfg_step);
  assign half_w_ext = PW'(cfg_w >> 1);
  assign half_h_ext = PW'(cfg_h >> 1);

`ifdef PIXEL_CENTER_EN
  logic signed [WORD_LENGTH-1:0] half_step;
  assign half_step     = cfg_step >>> 1;
  assign real_min_calc = cfg_rc - WORD_LENGTH'(half_w_ext * step_ext) + half_step;
  assign imag_max_calc = cfg_ic + WORD_LENGTH'(half_h_ext * step_ext) - half_step;
`else
  assign real_min_calc = cfg_rc - WORD_LENGTH'(half_w_ext * step_ext);
  assign imag_max_calc = cfg_ic + WORD_LENGTH'(half_h_ext * step_ext);
`endif

  assign row_step = cfg_step <<< LANE_SHIFT;

  // One extra bit so x + NUM_LANES cannot wrap near the maximum width.
  logic [COORD_W:0] x_next_ext;
  logic             row_end;
  logic             last_row;
  logic             fire;

  assign x_next_ext = {1'b0, out_x} + (COORD_W+1)'(NUM_LANES);
  assign row_end    = x_next_ext >= {1'b0, cfg_w};
  assign last_row   = out_y == (cfg_h - COORD_W'(1));
  assign out_last   = out_valid & last_row & row_end;
  assign fire       = out_valid & out_ready;

  lane_offset_gen #(
    .WORD_LENGTH (WORD_LENGTH),
    .NUM_LANES   (NUM_LANES)
  ) u_lane_offset_gen (
    .clk     (clk),
    .reset   (reset),
    .load    (state == ST_LOAD),
    .step    (cfg_step),
    .offsets (lane_off)
  );

  // Beat fields are pure functions of scan registers that only move on a
  // handshake, so they hold steady while the consumer stalls.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign out_real[i*WORD_LENGTH +: WORD_LENGTH] =
      row_real + lane_off[i*WORD_LENGTH +: WORD_LENGTH];
    assign out_lane_mask[i] =
      out_valid & (({1'b0, out_x} + (COORD_W+1)'(i)) < {1'b0, cfg_w});
  end

  // NOTE: every register here uses <= so all updates see pre-edge values,
  // regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      cfg_w      <= '0;
      cfg_h      <= '0;
      cfg_rc     <= '0;
      cfg_ic     <= '0;
      cfg_step   <= '0;
      real_min   <= '0;
      row_real   <= '0;
      out_imag   <= '0;
      out_x      <= '0;
      out_y      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          frame_done <= 1'b0;
          if (start) begin
            cfg_w    <= (screen_width  == '0) ? COORD_W'(1) : screen_width;
            cfg_h    <= (screen_height == '0) ? COORD_W'(1) : screen_height;
            cfg_rc   <= real_center;
            cfg_ic   <= imag_center;
            cfg_step <= step;
            busy     <= 1'b1;
            state    <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          real_min  <= real_min_calc;
          row_real  <= real_min_calc;
          out_imag  <= imag_max_calc;
          out_x     <= '0;
          out_y     <= '0;
          out_valid <= 1'b1;
          state     <= ST_SCAN;
        end

        ST_SCAN: begin
          if (fire) begin
            if (row_end) begin
              out_x    <= '0;
              row_real <= real_min;
              out_y    <= out_y + COORD_W'(1);
              out_imag <= out_imag - cfg_step;
            end else begin
              out_x    <= out_x + COORD_W'(NUM_LANES);
              row_real <= row_real + row_step;
            end
            if (out_last) begin
              out_valid  <= 1'b0;
              frame_done <= 1'b1;
              state      <= ST_DONE;
            end
          end
        end

        ST_DONE: begin
          frame_done <= 1'b0;
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_coord_stream.sv
// -----------------------------------------------------------------------------
// tb_pixel_coord_stream
// Self-checking bench for pixel_coord_stream (NUM_LANES=4, Q4.28). Expected
// beats are generated from the frame configuration by a direct (non
// incremental) model and queued when start is driven; each DUT handshake pops
// and compares one beat. Honours PIXEL_CENTER_EN in the same way as the RTL.
// -----------------------------------------------------------------------------
module tb_pixel_coord_stream;
  import mandel_pkg::*;

  localparam int WL = 32;
  localparam int NL = 4;
  localparam int CW = 11;

  typedef struct packed {
    logic [NL*WL-1:0] re;
    logic [WL-1:0]    im;
    logic [CW-1:0]    x;
    logic [CW-1:0]    y;
    logic [NL-1:0]    mask;
    logic             last;
  } beat_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [CW-1:0]     screen_width;
  logic [CW-1:0]     screen_height;
  logic [WL-1:0]     real_center;
  logic [WL-1:0]     imag_center;
  logic [WL-1:0]     step;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic [NL*WL-1:0]  out_real;
  logic [WL-1:0]     out_imag;
  logic [CW-1:0]     out_x;
  logic [CW-1:0]     out_y;
  logic [NL-1:0]     out_lane_mask;
  logic              out_last;
  logic              frame_done;

  pixel_coord_stream #(
    .WORD_LENGTH (WL),
    .FRAC        (28),
    .NUM_LANES   (NL),
    .COORD_W     (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .screen_width  (screen_width),
    .screen_height (screen_height),
    .real_center   (real_center),
    .imag_center   (imag_center),
    .step          (step),
    .busy          (busy),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_real      (out_real),
    .out_imag      (out_imag),
    .out_x         (out_x),
    .out_y         (out_y),
    .out_lane_mask (out_lane_mask),
    .out_last      (out_last),
    .frame_done    (frame_done)
  );

  always #5 clk = ~clk;

  beat_t exp_q[$];
  beat_t cap_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  logic [WL-1:0] unit_step;

  // Direct model: pixel (x, y) real = real_min + x*step, imag = imag_max - y*step.
  task automatic build_expected(input logic [CW-1:0] w, input logic [CW-1:0] h,
                                input logic [WL-1:0] rc, input logic [WL-1:0] ic,
                                input logic [WL-1:0] st);
    int unsigned   ew, eh, nb, px;
    logic [WL-1:0] rm, im, hs;
    beat_t         e;
    ew = (w == 0) ? 1 : int'(w);
    eh = (h == 0) ? 1 : int'(h);
    rm = rc - 32'(longint'(ew / 2) * longint'($signed(st)));
    im = ic + 32'(longint'(eh / 2) * longint'($signed(st)));
`ifdef PIXEL_CENTER_EN
    hs = $signed(st) >>> 1;
    rm = rm + hs;
    im = im - hs;
`else
    hs = '0;
`endif
    nb = (ew + NL - 1) / NL;
    for (int r = 0; r < int'(eh); r++) begin
      for (int b = 0; b < int'(nb); b++) begin
        px = b * NL;
        for (int i = 0; i < NL; i++) begin
          e.re[i*WL +: WL] = rm + 32'(longint'(px + i) * longint'($signed(st)));
          e.mask[i]        = (px + i) < ew;
        end
        e.im   = im - 32'(longint'(r) * longint'($signed(st)));
        e.x    = CW'(px);
        e.y    = CW'(r);
        e.last = (r == int'(eh) - 1) && (b == int'(nb) - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  // Drives one frame and checks it beat by beat. Optional hooks: pulse a
  // bogus start at beat glitch_at, or assert reset at beat abort_at.
  task automatic run_frame(input logic [CW-1:0] w, input logic [CW-1:0] h,
                           input logic [WL-1:0] rc, input logic [WL-1:0] ic,
                           input logic [WL-1:0] st, input bit rand_ready,
                           input int glitch_at, input int abort_at);
    beat_t got, exp, prev;
    bit    prev_stall, glitched, done, r;
    int    nbeat, cyc;
    prev_stall = 0; glitched = 0; done = 0; nbeat = 0; cyc = 0;
    prev = '0;
    cap_q.delete();
    exp_q.delete();
    build_expected(w, h, rc, ic, st);
    screen_width = w; screen_height = h;
    real_center = rc; imag_center = ic; step = st;
    out_ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if ({busy, out_valid} !== 2'b10) begin
      n_bad++;
      $display("FAIL load_phase: busy,valid=%b expected 10", {busy, out_valid});
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL first_valid_latency: valid=%b expected 1", out_valid);
    end
    while (!done && cyc < 4000) begin
      start = 1'b0;
      got = beat_t'({out_real, out_imag, out_x, out_y, out_lane_mask, out_last});
      if (prev_stall) begin
        n_cmp++;
        if (got !== prev) begin
          n_bad++;
          $display("FAIL stall_stable: got %h expected %h", got, prev);
        end
      end
      n_cmp++;
      if (frame_done !== 1'b0) begin
        n_bad++;
        $display("FAIL early_frame_done: frame_done=%b expected 0", frame_done);
      end
      if (abort_at >= 0 && nbeat == abort_at) begin
        reset = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++;
        if ({out_valid, busy} !== 2'b00) begin
          n_bad++;
          $display("FAIL abort_outputs: valid,busy=%b expected 00", {out_valid, busy});
        end
        repeat (4) begin
          @(negedge clk);
          n_cmp++;
          if ({frame_done, busy, out_valid} !== 3'b000) begin
            n_bad++;
            $display("FAIL abort_quiet: done,busy,valid=%b expected 000",
                     {frame_done, busy, out_valid});
          end
        end
        exp_q.delete();
        return;
      end
      if (glitch_at >= 0 && nbeat == glitch_at && !glitched) begin
        glitched = 1;
        start = 1'b1;
        screen_width = 11'd3; screen_height = 11'd1;
        real_center = 32'h12345678; imag_center = '1; step = 32'h00100000;
      end
      r = rand_ready ? ($urandom_range(0, 9) < 6) : 1'b1;
      out_ready = r;
      if (out_valid && r) begin
        cap_q.push_back(got);
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL extra_beat%0d: got %h expected none", nbeat, got);
        end else begin
          exp = exp_q.pop_front();
          n_cmp++;
          if (got.re !== exp.re) begin
            n_bad++;
            $display("FAIL beat%0d_real: got %h expected %h", nbeat, got.re, exp.re);
          end
          n_cmp++;
          if ({got.im, got.x, got.y, got.mask, got.last} !==
              {exp.im, exp.x, exp.y, exp.mask, exp.last}) begin
            n_bad++;
            $display("FAIL beat%0d_fields: got im=%h x=%0d y=%0d m=%b l=%b expected im=%h x=%0d y=%0d m=%b l=%b",
                     nbeat, got.im, got.x, got.y, got.mask, got.last,
                     exp.im, exp.x, exp.y, exp.mask, exp.last);
          end
          if (exp.last) done = 1;
        end
        nbeat++;
      end
      prev = got;
      prev_stall = out_valid && !r;
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL frame_timeout: beats=%0d expected %0d", nbeat, nbeat + exp_q.size());
      return;
    end
    n_cmp++;
    if ({frame_done, busy, out_valid} !== 3'b110) begin
      n_bad++;
      $display("FAIL done_cycle: done,busy,valid=%b expected 110", {frame_done, busy, out_valid});
    end
    @(negedge clk);
    n_cmp++;
    if ({frame_done, busy, out_valid} !== 3'b000) begin
      n_bad++;
      $display("FAIL after_done: done,busy,valid=%b expected 000", {frame_done, busy, out_valid});
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL beats_left: got %0d expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b1;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    n_cmp++;
    if ({busy, out_valid, out_real, out_imag, out_x, out_y, out_lane_mask, out_last, frame_done} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: busy=%b valid=%b real=%h imag=%h expected all 0",
               busy, out_valid, out_real, out_imag);
    end
    @(negedge clk);
    n_cmp++;
    if ({busy, out_valid} !== 2'b00) begin
      n_bad++;
      $display("FAIL start_with_reset: busy,valid=%b expected 00", {busy, out_valid});
    end
  endtask

  task automatic test_basic_frame;
    logic [NL*WL-1:0] want_re;
    logic [WL-1:0]    want_im0, want_iml;
`ifdef PIXEL_CENTER_EN
    want_re  = {32'hFF800000, 32'hFE800000, 32'hFD800000, 32'hFC800000};
    want_im0 = 32'h01800000;
    want_iml = 32'hFE800000;
`else
    want_re  = {32'hFF000000, 32'hFE000000, 32'hFD000000, 32'hFC000000};
    want_im0 = 32'h02000000;
    want_iml = 32'hFF000000;
`endif
    run_frame(11'd8, 11'd4, '0, '0, unit_step, 1'b0, -1, -1);
    n_cmp++;
    if (cap_q.size() != 8) begin
      n_bad++;
      $display("FAIL basic_beat_count: got %0d expected 8", cap_q.size());
    end else begin
      n_cmp++;
      if ({cap_q[0].re, cap_q[0].im} !== {want_re, want_im0}) begin
        n_bad++;
        $display("FAIL basic_first_beat: got %h/%h expected %h/%h",
                 cap_q[0].re, cap_q[0].im, want_re, want_im0);
      end
      n_cmp++;
      if ({cap_q[7].im, cap_q[7].last} !== {want_iml, 1'b1}) begin
        n_bad++;
        $display("FAIL basic_last_beat: got %h/%b expected %h/1",
                 cap_q[7].im, cap_q[7].last, want_iml);
      end
    end
  endtask

  task automatic test_backpressure;
    run_frame(11'd8, 11'd4, '0, '0, unit_step, 1'b1, -1, -1);
    run_frame(11'd13, 11'd3, 32'h00400000, 32'hFFC00000, 32'h00020000, 1'b1, -1, -1);
  endtask

  task automatic test_partial_row;
    run_frame(11'd6, 11'd2, '0, '0, unit_step, 1'b0, -1, -1);
    n_cmp++;
    if (cap_q.size() != 4) begin
      n_bad++;
      $display("FAIL partial_beat_count: got %0d expected 4", cap_q.size());
    end else begin
      n_cmp++;
      if ({cap_q[0].mask, cap_q[0].x, cap_q[1].mask, cap_q[1].x} !==
          {4'b1111, 11'd0, 4'b0011, 11'd4}) begin
        n_bad++;
        $display("FAIL partial_masks: got %b@%0d %b@%0d expected 1111@0 0011@4",
                 cap_q[0].mask, cap_q[0].x, cap_q[1].mask, cap_q[1].x);
      end
    end
  endtask

  task automatic test_restart_reset;
    run_frame(11'd8, 11'd4, '0, '0, unit_step, 1'b0, 3, -1);
    run_frame(11'd8, 11'd4, '0, '0, unit_step, 1'b0, -1, 3);
    run_frame(11'd6, 11'd3, 32'h00500000, 32'hFF000000, 32'h00080000, 1'b1, -1, -1);
  endtask

  task automatic test_wrap;
    logic [WL-1:0] want0;
`ifdef PIXEL_CENTER_EN
    want0 = 32'h47FFFFF0;
`else
    want0 = 32'h3FFFFFF0;
`endif
    run_frame(11'd40, 11'd2, 32'h7FFFFFF0, '0, 32'h10000000, 1'b1, -1, -1);
    n_cmp++;
    if (cap_q.size() == 0 || cap_q[0].re[WL-1:0] !== want0) begin
      n_bad++;
      $display("FAIL wrap_first_lane: got %h expected %h",
               (cap_q.size() == 0) ? 32'h0 : cap_q[0].re[WL-1:0], want0);
    end
  endtask

  task automatic test_zero_size;
    run_frame(11'd0, 11'd0, 32'h01000000, 32'h02000000, unit_step, 1'b0, -1, -1);
    n_cmp++;
    if (cap_q.size() != 1 || cap_q[0].mask !== 4'b0001) begin
      n_bad++;
      $display("FAIL zero_size: got %0d beats mask %b expected 1 beat mask 0001",
               cap_q.size(), (cap_q.size() == 0) ? 4'b0 : cap_q[0].mask);
    end
  endtask

  initial begin
    unit_step = FIXED_ONE >>> 4;
    reset = 1'b1; start = 1'b0; out_ready = 1'b0;
    screen_width = '0; screen_height = '0;
    real_center = '0; imag_center = '0; step = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_partial_row();
    test_restart_reset();
    test_wrap();
    test_zero_size();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pixel_coord_stream.md
Name: pixel_coord_stream

Overview:
- Multi-lane, raster-scanning pixel-to-complex mapper for the multi-engine Mandelbrot datapath.
- On a start pulse it latches the view configuration (centre, per-pixel step, screen size).
- It then streams NUM_LANES consecutive pixels per beat as signed fixed-point (real, imag) pairs over a valid/ready handshake to the engine dispatcher.
- Uses incremental adds instead of per-pixel multiply/divide. Zoom is expressed by the caller as the per-pixel step.

Parameters:
- WORD_LENGTH, 32, total bits of each signed fixed-point coordinate.
- FRAC, 28, fractional bits (default Q4.28).
- NUM_LANES, 4, pixels emitted per beat (power of two, 1..16).
- COORD_W, 11, width of pixel x/y counters and screen dimensions.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- start  in  1  single-cycle pulse; begin a frame (honoured only in IDLE)
- screen_width  in  COORD_W  pixels per row, >= 1
- screen_height  in  COORD_W  rows per frame, >= 1
- real_center  in  WORD_LENGTH  signed view centre, real axis
- imag_center  in  WORD_LENGTH  signed view centre, imaginary axis
- step  in  WORD_LENGTH  signed per-pixel increment (same Q format)
- busy  out  1  high from accepted start until frame_done
- out_valid  out  1  beat available
- out_ready  in  1  consumer accepts beat
- out_real  out  NUM_LANES*WORD_LENGTH  lane i at bits [i*WL +: WL]
- out_imag  out  WORD_LENGTH  row imaginary value, shared by all lanes
- out_x  out  COORD_W  x of lane 0
- out_y  out  COORD_W  row index
- out_lane_mask  out  NUM_LANES  bit i set if lane i is a real pixel
- out_last  out  1  final beat of frame
- frame_done  out  1  one-cycle pulse after final beat handshake

Behaviour:
- Clock is clk; reset is synchronous, active-high.
- Reset values: all outputs 0; state IDLE.
- Reset mid-frame discards the frame immediately; frame_done is not pulsed.
- FSM IDLE -> LOAD -> SCAN -> DONE -> IDLE.
- IDLE: start=1 latches all config inputs; go to LOAD. Config input changes after this have no effect until the next frame.
- LOAD (1 cycle):
  - real_min = real_center - (screen_width>>1)*step
  - imag_max = imag_center + (screen_height>>1)*step
  - Products are computed at full COORD_W+WL width, then truncated to the low WL bits (two's-complement wrap, no saturation).
  - Lane offsets k*step, k=0..NUM_LANES-1, are precomputed into registers.
  - x=0, y=0, row_real=real_min, out_imag=imag_max.
- SCAN: out_valid=1 with the first beat on the edge leaving LOAD (start-to-first-valid = 2 clocks).
  - Lane i: out_real = row_real + i*step.
  - out_lane_mask bit i = (x+i < screen_width).
  - Beat fields are stable while out_valid & !out_ready.
  - On each handshake:
    - x += NUM_LANES; row_real += NUM_LANES*step.
    - If x+NUM_LANES >= screen_width: x=0, row_real=real_min, y+=1, out_imag -= step.
  - out_last = (y == screen_height-1) & (x+NUM_LANES >= screen_width).
  - A handshake on out_last goes to DONE; out_valid drops the next cycle. Throughput is one beat per clock while ready is held high.
- DONE (1 cycle): frame_done=1, busy=0 next cycle; return to IDLE.
- start while busy is ignored (no queueing). start in the same cycle as reset is ignored.
- screen_width not a multiple of NUM_LANES: the final beat of each row has partial out_lane_mask; masked lanes still carry arithmetic values.
- Boundary: screen_width or screen_height = 0 is illegal; the block treats 0 as 1.

Optional Feature:
- Macro: PIXEL_CENTER_EN.
- Defined: LOAD adds step>>>1 to real_min and subtracts step>>>1 from imag_max, so each coordinate samples the pixel centre.
- Undefined: coordinates sample the pixel top-left corner, exactly as above.

Decomposition:
- Package mandel_pkg holds:
  - the fsm state enum
  - a typedef for the signed WORD_LENGTH coordinate
  - a constant FIXED_ONE = 1 <<< FRAC
- One sub-module, lane_offset_gen: registered k*step table for k=0..NUM_LANES-1, built by shift-and-add.

Test Plan:
- Basic frame. Setup: NUM_LANES=4, width=8, height=4, centres 0, step=0x01000000, ready held 1.
  - Beat 0: real lanes = -0x4000000, -0x3000000, -0x2000000, -0x1000000; imag = 0x2000000.
  - 8 beats total; last beat imag = -0x1000000 with out_last=1; frame_done one cycle after the last handshake.
- Back-pressure: toggle out_ready pseudo-randomly.
  - Output fields stay stable whenever valid & !ready.
  - Pixel sequence is identical to the ready=1 run.
- Partial row: width=6, NUM_LANES=4 -> each row gives beats with masks 1111 then 0011; out_x = 0, 4.
- Restart/reset: start pulsed during SCAN is ignored. Reset asserted mid-SCAN -> next cycle out_valid=0, busy=0, no frame_done. A new start afterwards gives a correct frame.
- Wrap: real_center = 0x7FFFFFF0 with a large positive step -> lane values wrap in two's complement, matching the reference model bit-exactly.
- PIXEL_CENTER_EN defined, basic-frame setup -> first lane real = -0x3800000, imag = 0x1800000.
